// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, finds the start bit on a
// falling edge, samples each bit at mid-bit and presents the word with
// parity/framing flags behind a valid/ready handshake with overrun tracking.
module uart_rx #(
  parameter int    WORD_LENGTH = 8,
  parameter string PARITY      = "none",
  parameter int    STOP_BITS   = 1,
  parameter int    BAUD_RATE   = 9600,
  parameter int    CLK_FREQ    = 50_000_000
) (
  input  logic                   clk_glb,
  input  logic                   reset,
  input  logic                   i_rx,
  input  logic                   rx_ready,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(WORD_LENGTH + 1);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WORD_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != "none");
  localparam bit               ODD_PARITY = (PARITY == "odd");

  // A bit period shorter than 4 clocks leaves no room for mid-bit sampling
  if (CLKS_PER_BIT < 4) begin : g_badRate
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } stateType;

  stateType               r_state;
  stateType               w_stateNext;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_rxPrev;
  logic [CNT_W-1:0]       r_count;
  logic [IDX_W-1:0]       r_bitIdx;
  logic [WORD_LENGTH-1:0] r_shift;
  logic                   r_parityBit;
  logic                   r_stopErr;
  logic                   r_loadPending;
  logic                   w_fall;
  logic                   w_bitEnd;
  logic                   w_sample;
  logic                   w_frameDone;
  logic                   w_parityErr;

  assign w_fall      = ~r_sync2 & r_rxPrev;
  assign w_bitEnd    = (r_count == LAST_CNT);
  assign w_parityErr = HAS_PARITY & ((^r_shift) ^ r_parityBit ^ ODD_PARITY);
  assign rx_busy     = (r_state != S_IDLE);

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk_glb) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= i_rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk_glb) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the bit-sample strobe
  always_comb begin
    w_stateNext = r_state;
    w_sample    = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_stateNext = S_START;
      end
      S_START: begin
        if (r_count == HALF_CNT) w_stateNext = r_sync2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_sample = 1'b1;
          if (r_bitIdx == LAST_DATA) w_stateNext = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bitEnd) begin
          w_sample    = 1'b1;
          w_stateNext = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          w_sample = 1'b1;
          if (r_bitIdx == LAST_STOP) begin
            w_stateNext = S_IDLE;
            w_frameDone = 1'b1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Bit timing, bit index and the captured frame contents
  always_ff @(posedge clk_glb) begin
    if (reset) begin
      r_count       <= '0;
      r_bitIdx      <= '0;
      r_shift       <= '0;
      r_parityBit   <= 1'b0;
      r_stopErr     <= 1'b0;
      r_loadPending <= 1'b0;
    end else begin
      r_loadPending <= w_frameDone;
      if ((w_stateNext != r_state) || w_sample || (r_state == S_IDLE)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_stateNext != r_state) begin
        r_bitIdx <= '0;
      end else if (w_sample) begin
        r_bitIdx <= r_bitIdx + IDX_W'(1);
      end
      if (r_state == S_START && w_stateNext == S_DATA) begin
        r_stopErr <= 1'b0;
      end else if (w_sample && r_state == S_STOP && !r_sync2) begin
        r_stopErr <= 1'b1;
      end
      if (w_sample && r_state == S_DATA) begin
        r_shift <= {r_sync2, r_shift[WORD_LENGTH-1:1]};
      end
      if (w_sample && r_state == S_PARITY) begin
        r_parityBit <= r_sync2;
      end
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk_glb) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (r_loadPending) begin
      rx_data    <= r_shift;
      parity_err <= w_parityErr;
      frame_err  <= r_stopErr;
      rx_valid   <= 1'b1;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: one receiver without
// parity and one with even parity, driven frame by frame on the serial line.
module tb_uart_rx;

  localparam int BIT_CLKS = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxLine;
  logic       rxLineEven;
  logic       rxReady;
  logic       rxReadyEven;
  logic [7:0] rxData;
  logic       rxValid;
  logic       parityErr;
  logic       frameErr;
  logic       overrunFlag;
  logic       rxBusy;
  logic [7:0] eRxData;
  logic       eRxValid;
  logic       eParityErr;
  logic       eFrameErr;
  logic       eOverrun;
  logic       eRxBusy;

  int errorCount = 0;
  int checkCount = 0;
  int cycleCnt   = 0;
  int riseCycle  = 0;
  int riseCount  = 0;
  int busyCount  = 0;
  int startCycle = 0;
  int marker     = 0;
  bit prevValid  = 1'b0;

  uart_rx #(
    .WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(1),
    .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)
  ) dut (
    .clk_glb(clk), .reset(reset), .i_rx(rxLine), .rx_ready(rxReady),
    .rx_data(rxData), .rx_valid(rxValid), .parity_err(parityErr),
    .frame_err(frameErr), .overrun(overrunFlag), .rx_busy(rxBusy)
  );

  uart_rx #(
    .WORD_LENGTH(8), .PARITY("even"), .STOP_BITS(1),
    .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)
  ) dutEven (
    .clk_glb(clk), .reset(reset), .i_rx(rxLineEven), .rx_ready(rxReadyEven),
    .rx_data(eRxData), .rx_valid(eRxValid), .parity_err(eParityErr),
    .frame_err(eFrameErr), .overrun(eOverrun), .rx_busy(eRxBusy)
  );

  always #5 clk = ~clk;

  // Count clocks, rx_valid rising edges and busy cycles just after each edge
  always @(posedge clk) begin
    cycleCnt++;
    #1;
    if (rxValid && !prevValid) begin
      riseCycle = cycleCnt;
      riseCount++;
    end
    prevValid = rxValid;
    if (rxBusy) busyCount++;
  end

  // Hard stop in case something stalls the directed sequence
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyBit(input bit toEven, input logic v);
    if (toEven) rxLineEven = v;
    else rxLine = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit toEven, input logic [7:0] data,
                               input bit withParity, input logic parityBit,
                               input logic stopBit);
    startCycle = cycleCnt;
    applyBit(toEven, 1'b0);
    for (int i = 0; i < 8; i++) applyBit(toEven, data[i]);
    if (withParity) applyBit(toEven, parityBit);
    applyBit(toEven, stopBit);
  endtask

  initial begin
    rxLine      = 1'b1;
    rxLineEven  = 1'b1;
    rxReady     = 1'b0;
    rxReadyEven = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", 32'(rxData), 0);
    checkOutput("rst_valid", 32'(rxValid), 0);
    checkOutput("rst_perr", 32'(parityErr), 0);
    checkOutput("rst_ferr", 32'(frameErr), 0);
    checkOutput("rst_overrun", 32'(overrunFlag), 0);
    checkOutput("rst_busy", 32'(rxBusy), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame 0xA5
    marker = riseCount;
    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("a5_data", 32'(rxData), 32'hA5);
    checkOutput("a5_valid", 32'(rxValid), 1);
    checkOutput("a5_perr", 32'(parityErr), 0);
    checkOutput("a5_ferr", 32'(frameErr), 0);
    checkOutput("a5_overrun", 32'(overrunFlag), 0);
    checkOutput("a5_words", 32'(riseCount - marker), 1);
    checkOutput("a5_latency_window",
                32'((riseCycle - startCycle >= 97) && (riseCycle - startCycle <= 100)), 1);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    checkOutput("a5_consumed", 32'(rxValid), 0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("even_bad_valid", 32'(eRxValid), 1);
    checkOutput("even_bad_data", 32'(eRxData), 32'h07);
    checkOutput("even_bad_perr", 32'(eParityErr), 1);
    checkOutput("even_bad_ferr", 32'(eFrameErr), 0);
    rxReadyEven = 1'b1;
    @(negedge clk);
    rxReadyEven = 1'b0;
    checkOutput("even_consumed", 32'(eRxValid), 0);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("even_good_valid", 32'(eRxValid), 1);
    checkOutput("even_good_perr", 32'(eParityErr), 0);
    rxReadyEven = 1'b1;
    @(negedge clk);
    rxReadyEven = 1'b0;

    // Stop bit low, line left low: one word with frame error, no new start
    marker = riseCount;
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("ferr_valid", 32'(rxValid), 1);
    checkOutput("ferr_data", 32'(rxData), 32'h3C);
    checkOutput("ferr_flag", 32'(frameErr), 1);
    checkOutput("ferr_perr", 32'(parityErr), 0);
    checkOutput("ferr_idle_while_low", 32'(rxBusy), 0);
    checkOutput("ferr_one_word", 32'(riseCount - marker), 1);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    rxLine = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("ferr_no_restart_busy", 32'(rxBusy), 0);
    checkOutput("ferr_no_restart_valid", 32'(rxValid), 0);

    // Three-cycle glitch: busy pulses, no word
    marker = riseCount;
    startCycle = busyCount;
    rxLine = 1'b0;
    repeat (3) @(negedge clk);
    rxLine = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_seen", 32'(busyCount > startCycle), 1);
    checkOutput("glitch_busy_done", 32'(rxBusy), 0);
    checkOutput("glitch_no_valid", 32'(rxValid), 0);
    checkOutput("glitch_no_word", 32'(riseCount - marker), 0);

    // Two words without consuming: second overwrites, overrun set
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("ovr_first_data", 32'(rxData), 32'h11);
    checkOutput("ovr_first_flag", 32'(overrunFlag), 0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("ovr_data", 32'(rxData), 32'h22);
    checkOutput("ovr_valid", 32'(rxValid), 1);
    checkOutput("ovr_flag", 32'(overrunFlag), 1);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    checkOutput("ovr_consumed_valid", 32'(rxValid), 0);
    checkOutput("ovr_consumed_flag", 32'(overrunFlag), 0);

    // Hold a word, then reset in the middle of data bit 4 of the next frame
    applyStimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_valid", 32'(rxValid), 1);
    rxLine = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxLine = 1'b1;
    repeat (4 * BIT_CLKS + 5) @(negedge clk);
    checkOutput("mid_busy", 32'(rxBusy), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_data", 32'(rxData), 0);
    checkOutput("midrst_valid", 32'(rxValid), 0);
    checkOutput("midrst_busy", 32'(rxBusy), 0);
    checkOutput("midrst_ferr", 32'(frameErr), 0);
    checkOutput("midrst_perr", 32'(parityErr), 0);
    checkOutput("midrst_overrun", 32'(overrunFlag), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("post_rst_data", 32'(rxData), 32'h5A);
    checkOutput("post_rst_valid", 32'(rxValid), 1);
    checkOutput("post_rst_ferr", 32'(frameErr), 0);
    checkOutput("post_rst_overrun", 32'(overrunFlag), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
